cdb_tx_buffer: RTL and testbench
================================

# cdb_tx_buffer

Per-functional-unit result staging buffer on the transmit side of the common data bus. It captures completed results (tag plus EX_MEM_PACKET) from one FU and presents the oldest to the CDB arbiter as a done/tag/value triple. It holds each result until the arbiter's broadcast shows this FU won, then retires it. One instance sits between each FU (ALU, MULT0, MULT1, LS, BR) and the CDB, so lower-priority FUs never lose results while a higher-priority FU owns the bus.

## Interface
- DEPTH, 4: result entries held; power of two, 2..16.
- FU_ID, ALU_FU: FU opcode this instance answers to in the CDB broadcast.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fu_valid  in  1  FU has a completed result this cycle.
- fu_tag  in  TAG_SIZE  destination tag of the result.
- fu_packet  in  EX_MEM_PACKET  result packet (alu_result, take_branch, ...).
- fu_stall  out  1  buffer full; FU must hold its result and not issue.
- done  out  1  head entry valid; drives the arbiter's done_* input.
- cdb_tag  out  TAG_SIZE  head entry tag.
- cdb_val  out  EX_MEM_PACKET  head entry packet.
- cdb_in  in  CDB_OUTPUT  this cycle's arbiter output, used as the grant.
- squash  in  1  mispredict flush; discard all held results.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; set on a push while full, cleared only by reset.

## Operation
- **Circular FIFO state:** head pointer, tail pointer and count.
- **Grant:** `grant = cdb_in.valid && cdb_in.fu_opcode == FU_ID && done`. A grant seen without `done` is ignored.
- **Push:** `fu_valid && !full` writes the tail entry and advances the tail.
- **Pop:** `grant` advances the head.
- **Pointer wrap:** pointers wrap modulo DEPTH.
- **Count update:** count changes by +1, −1, or 0 for push-only, pop-only, or both.
- **Empty:** `done = 0`. `cdb_tag` and `cdb_val` are don't-care (hold the stale head).
- **Full (count == DEPTH):**
  - `fu_stall = 1`.
  - A simultaneous pop does NOT release the stall in the same cycle; `fu_stall` is derived from count only.
  - A push while full is dropped and sets `overflow`. `overflow` is an assertion target; it must never fire in a legal system.
- **Squash:** next cycle head = tail = count = 0. Squash overrides any same-cycle push and pop; no entry survives.
- **Reset (asynchronous):** pointers, count and `overflow` go to 0; entry contents are undefined. Reset asserted mid-operation discards all entries immediately.

## Timing
- Output reset values:
  - `done = 0`
  - `fu_stall = 0`
  - `count = 0`
  - `overflow = 0`
  - `cdb_tag = 0`
  - `cdb_val = 0` (head entry reads zero-initialised storage)
- **Latency:** a result pushed at edge N drives `done` during cycle N+1. Minimum FU-to-broadcast latency is 1 cycle.
- **Grant timing:** the grant is combinational within the cycle (done → arbiter → `cdb_in` → grant). The pop takes effect at the next edge.
- **Back-to-back:** the next head appears the cycle after a pop, giving a sustained 1 result/cycle when granted every cycle.
- **Combinational path:** `fu_stall` is combinational from count only. There is no path from fu_* to done, except in bypass mode.

## Configuration
- **CDB_TX_BYPASS_EN defined:**
  - When the buffer is empty and `fu_valid` is set, the incoming result drives done/tag/val in the same cycle.
  - If granted, the result is not written.
  - If not granted, it is pushed normally.
  - Zero-cycle latency; adds a fu_valid → done → grant combinational path.
- **CDB_TX_BYPASS_EN undefined:** strictly registered outputs as described above.

## Structure
- CDB_TX_DEPTH default and the FU opcode enum (ALU_FU, MULT0_FU, MULT1_FU, LS_FU, BR_FU) belong in sys_defs.svh.
- A CDB_TX_ENTRY typedef (tag plus EX_MEM_PACKET) belongs in sys_defs.svh.
- One sub-module, `cdb_tx_fifo`: a generic pointer/count/storage FIFO parameterised on entry type width and DEPTH. The top level adds grant decode, squash and bypass.

## Test plan
- **Single result:** push tag 5, alu_result 0x2A at edge 0; grant in cycle 1 → done=1, cdb_tag=5, cdb_val.alu_result=0x2A in cycle 1; done=0 and count=0 in cycle 2.
- **Arbitration loss:** push tags 1,2,3 on consecutive edges while cdb_in.fu_opcode ≠ FU_ID → count=3, done held with tag 1. Then grant three cycles → tags 1,2,3 emitted in order.
- **Full:** DEPTH=4, push 4 with no grant → fu_stall=1. A 5th push → overflow=1, count stays 4. Grant plus push in the same cycle → count stays 4 and the tail wraps to index 1.
- **Squash:** count=3 with squash, push and grant all in the same cycle → next cycle count=0, done=0, fu_stall=0.
- **Reset mid-stream:** reset_n low between edges with count=2 → done=0 and count=0 immediately, without waiting for a clock edge.
- **Bypass (macro defined):** empty buffer, fu_valid with tag 7 and a grant in the same cycle → done=1 and cdb_tag=7 in that cycle, count stays 0.

Source files
------------

// File: rtl/cdb_tx_buffer_pkg.sv
// Shared types for the CDB transmit staging buffer: FU opcodes, result packet,
// arbiter broadcast and buffered entry.
package cdb_tx_buffer_pkg;

  localparam int unsigned TAG_SIZE     = 6;
  localparam int unsigned CDB_TX_DEPTH = 4;

  typedef enum logic [2:0] {
    ALU_FU   = 3'd0,
    MULT0_FU = 3'd1,
    MULT1_FU = 3'd2,
    LS_FU    = 3'd3,
    BR_FU    = 3'd4
  } fu_opcode_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic        take_branch;
    logic        halt;
  } EX_MEM_PACKET;

  typedef struct packed {
    logic       valid;
    fu_opcode_t fu_opcode;
  } CDB_OUTPUT;

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    EX_MEM_PACKET        packet;
  } CDB_TX_ENTRY;

  function automatic logic cdb_selects(input CDB_OUTPUT c, input fu_opcode_t id);
    return c.valid && (c.fu_opcode == id);
  endfunction

endpackage

// File: rtl/cdb_tx_buffer_if.sv
// FU-side result handshake and CDB-side done/tag/value/grant bundle.
interface cdb_tx_buffer_if;
  import cdb_tx_buffer_pkg::*;

  logic                fu_valid;
  logic [TAG_SIZE-1:0] fu_tag;
  EX_MEM_PACKET        fu_packet;
  logic                fu_stall;
  logic                done;
  logic [TAG_SIZE-1:0] cdb_tag;
  EX_MEM_PACKET        cdb_val;
  CDB_OUTPUT           cdb_in;

  modport master (
    output fu_valid, fu_tag, fu_packet, cdb_in,
    input  fu_stall, done, cdb_tag, cdb_val
  );

  modport slave (
    input  fu_valid, fu_tag, fu_packet, cdb_in,
    output fu_stall, done, cdb_tag, cdb_val
  );
endinterface

// File: rtl/cdb_tx_buffer_fifo.sv
// Generic circular FIFO: head/tail pointers, occupancy count, zeroed storage.
// A push while full is accepted only when a pop frees the head slot on the same edge.
module cdb_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[head];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[tail] <= wdata;
        tail      <= tail + PW'(1);
      end
      if (pop_ok) head <= head + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/cdb_tx_buffer.sv
// Per-FU result staging buffer for the CDB: grant decode, squash, sticky overflow.
// Define CDB_TX_BYPASS_EN to let a result reach the CDB in the cycle it arrives when empty.
module cdb_tx_buffer
  import cdb_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = CDB_TX_DEPTH,
  parameter fu_opcode_t  FU_ID = ALU_FU
) (
  input  logic                   clock,
  input  logic                   reset_n,
  cdb_tx_buffer_if.slave         bus,
  input  logic                   squash,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  CDB_TX_ENTRY head_entry;
  CDB_TX_ENTRY wr_entry;
  logic        full;
  logic        empty;
  logic        grant;
  logic        fifo_push;
  logic        fifo_pop;

  assign wr_entry.tag    = bus.fu_tag;
  assign wr_entry.packet = bus.fu_packet;
  assign bus.fu_stall    = full;

`ifdef CDB_TX_BYPASS_EN
  logic bypass;

  // An incoming result on an empty buffer is offered straight to the arbiter;
  // it is stored only if that offer is not taken.
  always_comb begin
    bypass      = empty && bus.fu_valid;
    bus.done    = !empty || bypass;
    bus.cdb_tag = bypass ? bus.fu_tag    : head_entry.tag;
    bus.cdb_val = bypass ? bus.fu_packet : head_entry.packet;
    grant       = cdb_selects(bus.cdb_in, FU_ID) && bus.done;
    fifo_pop    = grant && !empty;
    fifo_push   = bus.fu_valid && !(bypass && grant);
  end
`else
  always_comb begin
    bus.done    = !empty;
    bus.cdb_tag = head_entry.tag;
    bus.cdb_val = head_entry.packet;
    grant       = cdb_selects(bus.cdb_in, FU_ID) && bus.done;
    fifo_pop    = grant;
    fifo_push   = bus.fu_valid;
  end
`endif

  cdb_tx_fifo #(
    .WIDTH($bits(CDB_TX_ENTRY)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (squash),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (wr_entry),
    .rdata   (head_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow <= 1'b0;
    else if (bus.fu_valid && full && !fifo_pop && !squash) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_cdb_tx_buffer.sv
// Self-checking bench for cdb_tx_buffer: directed scenarios then random traffic,
// compared against a queue-based model of the buffer's rules.
module tb_cdb_tx_buffer;
  import cdb_tx_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam fu_opcode_t  FU_ID = ALU_FU;
`ifdef CDB_TX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       squash  = 1'b0;
  logic [2:0] count;
  logic       overflow;

  cdb_tx_buffer_if bus ();

  cdb_tx_buffer #(.DEPTH(DEPTH), .FU_ID(FU_ID)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .squash   (squash),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  CDB_TX_ENTRY q[$];
  bit          ovf_m = 1'b0;

  task automatic drive(input bit v, input logic [TAG_SIZE-1:0] t, input logic [31:0] r,
                       input bit cv, input fu_opcode_t op, input bit sq);
    bus.fu_valid  = v;
    bus.fu_tag    = t;
    bus.fu_packet = '{alu_result: r, take_branch: r[0], halt: r[1]};
    bus.cdb_in    = '{valid: cv, fu_opcode: op};
    squash        = sq;
  endtask

  function automatic bit byp_now();
    return BYP && (q.size() == 0) && bus.fu_valid;
  endfunction

  function automatic bit exp_done();
    return (q.size() != 0) || byp_now();
  endfunction

  task automatic cmp(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic check(input string nm);
    CDB_TX_ENTRY e;
    cmp({nm, " done"}, bus.done, exp_done());
    cmp({nm, " count"}, count, q.size());
    cmp({nm, " fu_stall"}, bus.fu_stall, q.size() == DEPTH);
    cmp({nm, " overflow"}, overflow, ovf_m);
    if (exp_done()) begin
      if (q.size() != 0) e = q[0];
      else begin
        e.tag    = bus.fu_tag;
        e.packet = bus.fu_packet;
      end
      cmp({nm, " cdb_tag"}, bus.cdb_tag, e.tag);
      cmp({nm, " cdb_val"}, bus.cdb_val, e.packet);
    end
  endtask

  // Apply the buffer's rules to this cycle's inputs, as they stand before the edge.
  task automatic model_edge();
    bit g, pop, push;
    CDB_TX_ENTRY ent;
    g = bus.cdb_in.valid && (bus.cdb_in.fu_opcode == FU_ID) && exp_done();
    if (squash) begin
      q.delete();
      return;
    end
    pop = g && (q.size() != 0);
    if (byp_now() && g) push = 1'b0;
    else                push = bus.fu_valid && ((q.size() < DEPTH) || pop);
    if (bus.fu_valid && (q.size() == DEPTH) && !pop) ovf_m = 1'b1;
    ent.tag    = bus.fu_tag;
    ent.packet = bus.fu_packet;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(ent);
  endtask

  task automatic step(input string nm);
    @(negedge clock);
    check(nm);
    model_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int unsigned sel;
    bit          v;
    drive(0, '0, '0, 0, ALU_FU, 0);
    #12;
    cmp("reset done", bus.done, 1'b0);
    cmp("reset count", count, 3'd0);
    cmp("reset fu_stall", bus.fu_stall, 1'b0);
    cmp("reset overflow", overflow, 1'b0);
    cmp("reset cdb_tag", bus.cdb_tag, '0);
    cmp("reset cdb_val", bus.cdb_val, '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

`ifdef CDB_TX_BYPASS_EN
    drive(1, 6'd7, 32'h77, 1, FU_ID, 0);
    @(negedge clock);
    cmp("bypass done", bus.done, 1'b1);
    cmp("bypass cdb_tag", bus.cdb_tag, 6'd7);
    model_edge();
    @(posedge clock);
    #1;
    cmp("bypass count", count, 3'd0);
`endif

    // Single result: push, grant next cycle, then empty.
    drive(1, 6'd5, 32'h2A, 0, FU_ID, 0);  step("single push");
    drive(0, '0, '0, 1, FU_ID, 0);        step("single grant");
    drive(0, '0, '0, 0, FU_ID, 0);        step("single after");

    // Arbitration loss then in-order drain.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 6'(i), 32'(i * 16), 1, MULT0_FU, 0);
      step("lose push");
    end
    drive(0, '0, '0, 1, MULT1_FU, 0);     step("lose hold");
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, '0, 1, FU_ID, 0);
      step("lose drain");
    end
    drive(0, '0, '0, 0, FU_ID, 0);        step("lose empty");

    // Full, dropped push, push+pop while full, drain to verify wrap order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'(10 + i), 32'(100 + i), 0, FU_ID, 0);
      step("full fill");
    end
    drive(1, 6'd14, 32'd104, 0, FU_ID, 0); step("full drop");
    drive(1, 6'd15, 32'd105, 1, FU_ID, 0); step("full pushpop");
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 1, FU_ID, 0);
      step("full drain");
    end
    drive(0, '0, '0, 0, FU_ID, 0);        step("full empty");

    // Squash beats a same-cycle push and grant.
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'(20 + i), 32'(200 + i), 0, FU_ID, 0);
      step("squash fill");
    end
    drive(1, 6'd23, 32'd203, 1, FU_ID, 1); step("squash all");
    drive(0, '0, '0, 0, FU_ID, 0);         step("squash after");

    // Asynchronous reset between edges.
    for (int i = 0; i < 2; i++) begin
      drive(1, 6'(30 + i), 32'(300 + i), 0, FU_ID, 0);
      step("rst fill");
    end
    drive(0, '0, '0, 0, FU_ID, 0);
    cmp("rst pre count", count, q.size());
    #2;
    reset_n = 1'b0;
    #1;
    cmp("rst async done", bus.done, 1'b0);
    cmp("rst async count", count, 3'd0);
    cmp("rst async overflow", overflow, 1'b0);
    q.delete();
    ovf_m = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Random traffic, mostly honouring the stall, occasional squash.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      v = ($urandom_range(0, 3) != 0) && ((q.size() < DEPTH) || ($urandom_range(0, 15) == 0));
      drive(v, 6'($urandom), $urandom, $urandom_range(0, 1) == 1,
            (sel < 4) ? FU_ID : fu_opcode_t'(sel - 3), $urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
